// File: rtl/pll_reset_sequencer.sv
// PLL lock consumer: synchronises the asynchronous lock flag, holds the core in reset until
// lock has been stable for STABLE_CYCLES cycles, then releases reset and produces
// phase-aligned /2 and /4 clock-enable strobes. Loss of lock re-enters reset.
// Optional feature macro: PLL_LOCK_LOSS_CNT_EN (saturating 8-bit lock-loss event counter).
module pll_reset_sequencer #(
   parameter int unsigned STABLE_CYCLES = 1024,
   parameter int unsigned CNT_W         = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_locked,
   output logic       reset_out,
   output logic       ready,
   output logic       ce_div2,
   output logic       ce_div4,
   output logic [7:0] lock_loss_cnt
);

   localparam logic [1:0] WAIT_LOCK = 2'd0;
   localparam logic [1:0] STABLE    = 2'd1;
   localparam logic [1:0] RUN       = 2'd2;

   localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             sync_s1_q;
   logic             locked_s_q;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
   logic             reset_out_q, reset_out_d;
   logic             ready_q;
   logic [1:0]       ce_cnt_q;
   logic             lock_lost;

   // Two-flop synchroniser; the only logic that samples pll_locked.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_s1_q  <= 1'b0;
         locked_s_q <= 1'b0;
      end else begin
         sync_s1_q  <= pll_locked;
         locked_s_q <= sync_s1_q;
      end
   end

   // Lock qualification FSM next-state logic.
   always_comb begin
      state_d     = state_q;
      stab_cnt_d  = stab_cnt_q;
      reset_out_d = reset_out_q;
      lock_lost   = 1'b0;
      case (state_q)
         WAIT_LOCK: begin
            reset_out_d = 1'b1;
            if (locked_s_q) begin
               state_d    = STABLE;
               stab_cnt_d = '0;
            end
         end
         STABLE: begin
            reset_out_d = 1'b1;
            if (!locked_s_q) begin
               state_d = WAIT_LOCK;
            end else if (stab_cnt_q == STAB_LAST) begin
               state_d     = RUN;
               reset_out_d = 1'b0;
            end else begin
               stab_cnt_d = stab_cnt_q + 1'b1;
            end
         end
         RUN: begin
            reset_out_d = 1'b0;
            if (!locked_s_q) begin
               state_d     = WAIT_LOCK;
               reset_out_d = 1'b1;
               lock_lost   = 1'b1;
            end
         end
         default: begin
            state_d     = WAIT_LOCK;
            reset_out_d = 1'b1;
         end
      endcase
   end

   // FSM state, stability counter and registered reset/ready outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= WAIT_LOCK;
         stab_cnt_q  <= '0;
         reset_out_q <= 1'b1;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         stab_cnt_q  <= stab_cnt_d;
         reset_out_q <= reset_out_d;
         // Follows RUN one cycle late, but drops on the same edge that leaves RUN.
         ready_q     <= (state_q == RUN) && (state_d == RUN);
      end
   end

   // Clock-enable phase counter, parked at 0 while the core is held in reset.
   always_ff @(posedge clk) begin
      if (rst || reset_out_q) begin
         ce_cnt_q <= 2'd0;
      end else begin
         ce_cnt_q <= ce_cnt_q + 2'd1;
      end
   end

`ifdef PLL_LOCK_LOSS_CNT_EN
   logic [7:0] loss_cnt_q;

   // Saturating count of RUN->WAIT_LOCK transitions; cleared only by rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         loss_cnt_q <= 8'd0;
      end else if (lock_lost && (loss_cnt_q != 8'hFF)) begin
         loss_cnt_q <= loss_cnt_q + 8'd1;
      end
   end

   assign lock_loss_cnt = loss_cnt_q;
`else
   logic unused_lock_lost;
   assign unused_lock_lost = lock_lost;
   assign lock_loss_cnt    = 8'd0;
`endif

   assign reset_out = reset_out_q;
   assign ready     = ready_q;
   assign ce_div2   = ce_cnt_q[0] & ~reset_out_q;
   assign ce_div4   = (ce_cnt_q == 2'd3) & ~reset_out_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer (STABLE_CYCLES = 4). The reference model works
// from the observable timing rules: reset_out is low after edge t exactly when the lock samples
// at edges t-2-N .. t-2 were all 1 with no rst at or after them up to edge t.
module tb_pll_reset_sequencer;

   localparam int unsigned N = 4;

   logic       clk;
   logic       rst;
   logic       pll_locked;
   logic       reset_out;
   logic       ready;
   logic       ce_div2;
   logic       ce_div4;
   logic [7:0] lock_loss_cnt;

   int tests    = 0;
   int failures = 0;

   // Reference model state
   int run_t  = 0;   // consecutive lock=1 samples ending at the latest edge
   int run_t1 = 0;
   int run_t2 = 0;
   bit rst_last = 1'b1;
   bit exp_ro   = 1'b1;
   bit prev_ro  = 1'b1;
   bit exp_ready, exp_ce2, exp_ce4;
   int low_len  = 0;  // edges reset_out has been low, counting the current one
   int exp_loss = 0;

   pll_reset_sequencer #(
      .STABLE_CYCLES(N),
      .CNT_W        (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pll_locked   (pll_locked),
      .reset_out    (reset_out),
      .ready        (ready),
      .ce_div2      (ce_div2),
      .ce_div4      (ce_div4),
      .lock_loss_cnt(lock_loss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_edge(input bit r, input bit lk);
      prev_ro = exp_ro;
      run_t2  = run_t1;
      run_t1  = run_t;
      run_t   = (r || !lk) ? 0 : run_t + 1;
      exp_ro  = r || rst_last || (run_t2 < int'(N) + 1);
      rst_last = r;
      exp_ready = !exp_ro && !prev_ro;
      low_len = exp_ro ? 0 : low_len + 1;
      exp_ce2 = !exp_ro && (((low_len - 1) % 2) == 1);
      exp_ce4 = !exp_ro && (((low_len - 1) % 4) == 3);
`ifdef PLL_LOCK_LOSS_CNT_EN
      if (r) exp_loss = 0;
      else if (!prev_ro && exp_ro && exp_loss < 255) exp_loss = exp_loss + 1;
`else
      exp_loss = 0;
`endif
   endtask

   task automatic check_outputs();
      tests++;
      assert (reset_out === exp_ro) else begin
         failures++;
         $error("FAIL reset_out t=%0t got %b exp %b", $time, reset_out, exp_ro);
      end
      tests++;
      assert (ready === exp_ready) else begin
         failures++;
         $error("FAIL ready t=%0t got %b exp %b", $time, ready, exp_ready);
      end
      tests++;
      assert (ce_div2 === exp_ce2) else begin
         failures++;
         $error("FAIL ce_div2 t=%0t got %b exp %b", $time, ce_div2, exp_ce2);
      end
      tests++;
      assert (ce_div4 === exp_ce4) else begin
         failures++;
         $error("FAIL ce_div4 t=%0t got %b exp %b", $time, ce_div4, exp_ce4);
      end
      tests++;
      assert (lock_loss_cnt === 8'(exp_loss)) else begin
         failures++;
         $error("FAIL lock_loss_cnt t=%0t got %0d exp %0d", $time, lock_loss_cnt, exp_loss);
      end
   endtask

   // Drive inputs away from the edge, take one edge, update the model, check 1 ns later.
   task automatic step(input bit r, input bit lk);
      rst        = r;
      pll_locked = lk;
      @(posedge clk);
      model_edge(r, lk);
      #1;
      check_outputs();
   endtask

   task automatic hold(input bit lk, input int n);
      for (int i = 0; i < n; i++) step(1'b0, lk);
   endtask

   initial begin
      rst        = 1'b1;
      pll_locked = 1'b0;

      // 1: reset, then no lock for a long time
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      hold(1'b0, 5000);

      // 2: clean lock, release and strobe phasing
      hold(1'b1, 20);

      // 3: drop to WAIT_LOCK, then a one-cycle glitch during qualification
      hold(1'b0, 5);
      hold(1'b1, 3);
      hold(1'b0, 1);
      hold(1'b1, 14);

      // 4: lock loss in RUN, then relock
      hold(1'b0, 4);
      hold(1'b1, 14);

      // 5: rst while qualifying with lock held high
      hold(1'b0, 4);
      hold(1'b1, 4);
      step(1'b1, 1'b1);
      hold(1'b1, 14);

      // Randomized lock behaviour with occasional rst
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0));
      end
      for (int i = 0; i < 20; i++) begin
         hold(1'b1, $urandom_range(0, 12));
         hold(1'b0, $urandom_range(1, 4));
      end

      // 6: 260 lock-loss events from a clean reset, then rst clears the count
      step(1'b1, 1'b0);
      for (int i = 0; i < 260; i++) begin
         hold(1'b1, int'(N) + 3 + $urandom_range(0, 3));
         hold(1'b0, $urandom_range(1, 3));
      end
      tests++;
`ifdef PLL_LOCK_LOSS_CNT_EN
      assert (lock_loss_cnt === 8'd255) else begin
         failures++;
         $error("FAIL loss_saturate got %0d exp 255", lock_loss_cnt);
      end
`else
      assert (lock_loss_cnt === 8'd0) else begin
         failures++;
         $error("FAIL loss_tied_off got %0d exp 0", lock_loss_cnt);
      end
`endif
      step(1'b1, 1'b0);
      tests++;
      assert (lock_loss_cnt === 8'd0) else begin
         failures++;
         $error("FAIL loss_cleared got %0d exp 0", lock_loss_cnt);
      end
      hold(1'b0, 3);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
